// File: rtl/toy_cpu_pkg.sv
// Shared encodings for the toy accumulator CPU: opcodes, ALU ops, PC mux selects,
// controller states and the decoded-opcode / control-output bundles.
package toy_cpu_pkg;

    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_STA  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOTA = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JMPI = 4'hB;
    localparam logic [3:0] OP_LDI  = 4'hC;
    localparam logic [3:0] OP_STT  = 4'hD;
    localparam logic [3:0] OP_MOVT = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_NOTA = 3'b110;

    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_IMM  = 2'd1;
    localparam logic [1:0] PC_DMEM = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StMem,
        StExec,
        StHalt,
        StError
    } state_e;

    typedef enum logic [1:0] {
        PcKindInc,
        PcKindImm,
        PcKindCond,
        PcKindDmem
    } pc_kind_e;

    typedef struct packed {
        logic       needs_mem;
        logic       is_write;
        logic       src_adr;
        logic       src_data;
        logic [2:0] alu_op;
        logic       wr_a;
        logic       src_a;
        logic       wr_t;
        pc_kind_e   pc_sel_kind;
    } dec_t;

    typedef struct packed {
        logic       imem_req;
        logic       rd_dmem;
        logic       wr_dmem;
        logic       src_adr;
        logic       src_data;
        logic       src_a;
        logic       wr_a;
        logic       wr_t;
        logic [2:0] alu_op;
        logic [1:0] src_pc;
        logic       pc_we;
        logic       halted;
    } ctrl_out_t;

endpackage

// File: rtl/toy_op_decode.sv
// Combinational opcode decoder: maps the latched opcode to the memory access kind
// and the datapath controls used during MEM and EXEC.
module toy_op_decode
    import toy_cpu_pkg::*;
(
    input  logic [3:0] op,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        dec.pc_sel_kind = PcKindInc;
        unique case (op)
            OP_LDA: begin
                dec.needs_mem = 1'b1;
                dec.wr_a      = 1'b1;
                dec.src_a     = 1'b1;
            end
            OP_STA: begin
                dec.needs_mem = 1'b1;
                dec.is_write  = 1'b1;
            end
            OP_ADD: begin
                dec.needs_mem = 1'b1;
                dec.wr_a      = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            OP_SUB: begin
                dec.needs_mem = 1'b1;
                dec.wr_a      = 1'b1;
                dec.alu_op    = ALU_SUB;
            end
            OP_AND: begin
                dec.needs_mem = 1'b1;
                dec.wr_a      = 1'b1;
                dec.alu_op    = ALU_AND;
            end
            OP_OR: begin
                dec.needs_mem = 1'b1;
                dec.wr_a      = 1'b1;
                dec.alu_op    = ALU_OR;
            end
            OP_XOR: begin
                dec.needs_mem = 1'b1;
                dec.wr_a      = 1'b1;
                dec.alu_op    = ALU_XOR;
            end
            OP_NOTA: begin
                dec.wr_a   = 1'b1;
                dec.alu_op = ALU_NOTA;
            end
            OP_JMP:  dec.pc_sel_kind = PcKindImm;
            OP_JZ:   dec.pc_sel_kind = PcKindCond;
            OP_JMPI: begin
                dec.needs_mem   = 1'b1;
                dec.pc_sel_kind = PcKindDmem;
            end
            // LDI reads through the address held in A
            OP_LDI: begin
                dec.needs_mem = 1'b1;
                dec.src_adr   = 1'b1;
                dec.wr_a      = 1'b1;
                dec.src_a     = 1'b1;
            end
            OP_STT: begin
                dec.needs_mem = 1'b1;
                dec.is_write  = 1'b1;
                dec.src_data  = 1'b1;
            end
            OP_MOVT: dec.wr_t = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/toy_multicycle_ctrl.sv
// Multi-cycle sequencer for the accumulator CPU: FETCH/DECODE/MEM/EXEC with req/ack
// memories, a watchdog that traps a hung memory, and a retired-instruction counter.
module toy_multicycle_ctrl
    import toy_cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             a_zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             rd_dmem,
    output logic             wr_dmem,
    output logic             src_adr,
    output logic             src_data,
    output logic             src_a,
    output logic             wr_a,
    output logic             wr_t,
    output logic [2:0]       alu_op,
    output logic [1:0]       src_pc,
    output logic             pc_we,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned     WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W:0]   WD_LIMIT = (WD_W + 1)'(TIMEOUT);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [WD_W:0]     wd_step;
    logic              wd_fire;
    logic              is_read;
    logic              err_q;
    logic [CNT_W-1:0]  retired_q;
    ctrl_out_t         out_q, out_d;
    dec_t              dec;

    toy_op_decode u_decode (
        .op  (op_q),
        .dec (dec)
    );

    assign wd_step = {1'b0, wd_q} + (WD_W + 1)'(1);
    assign wd_fire = (TIMEOUT != 0) && (wd_step == WD_LIMIT);
    assign is_read = dec.needs_mem & ~dec.is_write;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wd_d    = wd_q;
        unique case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    state_d = StFetch;
                    wd_d    = '0;
                end
            end
            StFetch: begin
                if (imem_ack) begin
                    op_d    = opcode;
                    state_d = StDecode;
                end else if (wd_fire) begin
                    state_d = StError;
                end else begin
                    wd_d = wd_step[WD_W-1:0];
                end
            end
            StDecode: begin
                if (op_q == OP_HALT) begin
                    state_d = StHalt;
                end else if (dec.needs_mem) begin
                    state_d = StMem;
                    wd_d    = '0;
                end else begin
                    state_d = StExec;
                end
            end
            StMem: begin
                if (dmem_ack) begin
                    state_d = StExec;
                end else if (wd_fire) begin
                    state_d = StError;
                end else begin
                    wd_d = wd_step[WD_W-1:0];
                end
            end
            StExec: begin
                state_d = StFetch;
                wd_d    = '0;
            end
            StError: ;
            default: state_d = StError;
        endcase
    end

    // Outputs are registered: decode them for the state being entered.
    always_comb begin
        out_d = '0;
        unique case (state_d)
            StFetch: out_d.imem_req = 1'b1;
            StMem: begin
                out_d.rd_dmem  = is_read;
                out_d.wr_dmem  = dec.is_write;
                out_d.src_adr  = dec.src_adr;
                out_d.src_data = dec.src_data;
            end
            StExec: begin
                // Reads keep the request up so the load data stays valid for A/PC
                out_d.rd_dmem = is_read;
                out_d.src_adr = dec.src_adr & is_read;
                out_d.wr_a    = dec.wr_a;
                out_d.src_a   = dec.src_a;
                out_d.wr_t    = dec.wr_t;
                out_d.alu_op  = dec.alu_op;
                out_d.pc_we   = 1'b1;
                unique case (dec.pc_sel_kind)
                    PcKindImm:  out_d.src_pc = PC_IMM;
                    PcKindCond: out_d.src_pc = a_zero ? PC_IMM : PC_INC;
                    PcKindDmem: out_d.src_pc = PC_DMEM;
                    default:    out_d.src_pc = PC_INC;
                endcase
            end
            StHalt: begin
                out_d.halted = 1'b1;
                out_d.pc_we  = (state_q == StDecode);
                out_d.src_pc = PC_INC;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            wd_q      <= '0;
            out_q     <= '0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wd_q    <= wd_d;
            out_q   <= out_d;
            if (state_d == StError) begin
                err_q <= 1'b1;
            end
            if ((state_d == StExec) || (state_d == StHalt && state_q == StDecode)) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign imem_req = out_q.imem_req;
    assign rd_dmem  = out_q.rd_dmem;
    assign wr_dmem  = out_q.wr_dmem;
    assign src_adr  = out_q.src_adr;
    assign src_data = out_q.src_data;
    assign src_a    = out_q.src_a;
    assign wr_a     = out_q.wr_a;
    assign wr_t     = out_q.wr_t;
    assign alu_op   = out_q.alu_op;
    assign src_pc   = out_q.src_pc;
    assign pc_we    = out_q.pc_we;
    assign halted   = out_q.halted;
    assign err      = err_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_toy_multicycle_ctrl.sv
// Bench for toy_multicycle_ctrl: a table of hand-computed instruction vectors, hand
// sequences for HALT / reset / watchdog, and random instructions against a model.
module tb_toy_multicycle_ctrl;

    typedef struct packed {
        logic       imem_req;
        logic       rd_dmem;
        logic       wr_dmem;
        logic       src_adr;
        logic       src_data;
        logic       src_a;
        logic       wr_a;
        logic       wr_t;
        logic [2:0] alu_op;
        logic [1:0] src_pc;
        logic       pc_we;
        logic       halted;
        logic       err;
    } out_t;

    typedef struct {
        logic [3:0] op;
        logic       az;
        int         di;
        int         dd;
        logic       has_mem;
        out_t       mem;
        out_t       exe;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       a_zero = 1'b0;
    logic       imem_ack = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       imem_req, rd_dmem, wr_dmem, src_adr, src_data, src_a, wr_a, wr_t;
    logic [2:0] alu_op;
    logic [1:0] src_pc;
    logic       pc_we, halted, err;
    logic [3:0] retired;
    out_t       act;

    int n_checks  = 0;
    int n_pass    = 0;
    int ret_model = 0;
    vec_t vecs[$];

    toy_multicycle_ctrl #(
        .TIMEOUT (8),
        .CNT_W   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .opcode   (opcode),
        .a_zero   (a_zero),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .imem_req (imem_req),
        .rd_dmem  (rd_dmem),
        .wr_dmem  (wr_dmem),
        .src_adr  (src_adr),
        .src_data (src_data),
        .src_a    (src_a),
        .wr_a     (wr_a),
        .wr_t     (wr_t),
        .alu_op   (alu_op),
        .src_pc   (src_pc),
        .pc_we    (pc_we),
        .halted   (halted),
        .err      (err),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    assign act = {imem_req, rd_dmem, wr_dmem, src_adr, src_data, src_a, wr_a, wr_t,
                  alu_op, src_pc, pc_we, halted, err};

    function automatic out_t o_fetch();
        out_t r = '0;
        r.imem_req = 1'b1;
        return r;
    endfunction

    function automatic out_t o_halt(input logic pw);
        out_t r = '0;
        r.halted = 1'b1;
        r.pc_we  = pw;
        return r;
    endfunction

    function automatic out_t o_err();
        out_t r = '0;
        r.err = 1'b1;
        return r;
    endfunction

    function automatic out_t mm(input logic rd, input logic wr, input logic sadr,
                                input logic sdat);
        out_t r = '0;
        r.rd_dmem  = rd;
        r.wr_dmem  = wr;
        r.src_adr  = sadr;
        r.src_data = sdat;
        return r;
    endfunction

    function automatic out_t ex(input logic rd, input logic sadr, input logic wa,
                                input logic sa, input logic wt, input logic [2:0] alu,
                                input logic [1:0] spc);
        out_t r = '0;
        r.rd_dmem = rd;
        r.src_adr = sadr;
        r.wr_a    = wa;
        r.src_a   = sa;
        r.wr_t    = wt;
        r.alu_op  = alu;
        r.src_pc  = spc;
        r.pc_we   = 1'b1;
        return r;
    endfunction

    // Reference model: instruction classes straight from the opcode table.
    function automatic logic m_reads(input logic [3:0] op);
        return op inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB, 4'hC};
    endfunction

    function automatic logic m_writes(input logic [3:0] op);
        return op inside {4'h2, 4'hD};
    endfunction

    function automatic out_t m_mem(input logic [3:0] op);
        return mm(m_reads(op), m_writes(op), op == 4'hC, op == 4'hD);
    endfunction

    function automatic out_t m_exec(input logic [3:0] op, input logic az);
        out_t r = '0;
        r.pc_we   = 1'b1;
        r.rd_dmem = m_reads(op);
        r.src_adr = (op == 4'hC);
        if (op == 4'h1 || op == 4'hC) begin
            r.wr_a  = 1'b1;
            r.src_a = 1'b1;
        end
        if (op >= 4'h3 && op <= 4'h7) begin
            r.wr_a   = 1'b1;
            r.alu_op = 3'(op - 4'h3);
        end
        if (op == 4'h8) begin
            r.wr_a   = 1'b1;
            r.alu_op = 3'b110;
        end
        if (op == 4'hE) r.wr_t = 1'b1;
        if (op == 4'h9) r.src_pc = 2'd1;
        if (op == 4'hA) r.src_pc = az ? 2'd1 : 2'd0;
        if (op == 4'hB) r.src_pc = 2'd2;
        return r;
    endfunction

    task automatic check(input string name, input out_t exp);
        n_checks++;
        if (act === exp && retired === 4'(ret_model)) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got out=%b retired=%0d, want out=%b retired=%0d",
                     name, act, retired, exp, ret_model);
        end
    endtask

    task automatic step(input string name, input out_t exp);
        @(negedge clk);
        check(name, exp);
        @(posedge clk);
        #1;
    endtask

    // Entered one tick after the edge that put the DUT in FETCH.
    task automatic run_instr(input logic [3:0] op, input logic az, input int di, input int dd,
                             input logic has_mem, input out_t mem_exp, input out_t exe_exp);
        a_zero = az;
        for (int c = 0; c <= di; c++) begin
            opcode   = (c == di) ? op : 4'($urandom);
            imem_ack = (c == di);
            dmem_ack = 1'($urandom);
            start    = 1'($urandom);
            step($sformatf("fetch op%h", op), o_fetch());
        end
        opcode   = 4'($urandom);
        imem_ack = 1'($urandom);
        dmem_ack = 1'($urandom);
        step($sformatf("decode op%h", op), '0);
        if (op == 4'h0) begin
            start     = 1'b0;
            ret_model = (ret_model + 1) % 16;
            step("halt_entry", o_halt(1'b1));
            return;
        end
        if (has_mem) begin
            for (int c = 0; c <= dd; c++) begin
                dmem_ack = (c == dd);
                imem_ack = 1'($urandom);
                start    = 1'($urandom);
                step($sformatf("mem op%h", op), mem_exp);
            end
        end
        dmem_ack  = 1'($urandom);
        imem_ack  = 1'($urandom);
        start     = 1'($urandom);
        ret_model = (ret_model + 1) % 16;
        step($sformatf("exec op%h az%0d", op, az), exe_exp);
    endtask

    task automatic resume_from_halt();
        start = 1'b0;
        repeat (2) step("halt_hold", o_halt(1'b0));
        start = 1'b1;
        step("halt_start", o_halt(1'b0));
        start = 1'b0;
    endtask

    task automatic add_vec(input logic [3:0] op, input logic az, input int di, input int dd,
                           input logic has_mem, input out_t mem, input out_t exe);
        vec_t v;
        v.op = op; v.az = az; v.di = di; v.dd = dd;
        v.has_mem = has_mem; v.mem = mem; v.exe = exe;
        vecs.push_back(v);
    endtask

    initial begin
        add_vec(4'hF, 0, 0, 0, 0, '0, ex(0, 0, 0, 0, 0, 3'b000, 2'd0));
        add_vec(4'h1, 0, 0, 2, 1, mm(1, 0, 0, 0), ex(1, 0, 1, 1, 0, 3'b000, 2'd0));
        add_vec(4'hA, 1, 0, 0, 0, '0, ex(0, 0, 0, 0, 0, 3'b000, 2'd1));
        add_vec(4'hA, 0, 1, 0, 0, '0, ex(0, 0, 0, 0, 0, 3'b000, 2'd0));
        add_vec(4'hD, 0, 0, 1, 1, mm(0, 1, 0, 1), ex(0, 0, 0, 0, 0, 3'b000, 2'd0));
        add_vec(4'h3, 0, 0, 0, 1, mm(1, 0, 0, 0), ex(1, 0, 1, 0, 0, 3'b000, 2'd0));
        add_vec(4'h4, 0, 2, 0, 1, mm(1, 0, 0, 0), ex(1, 0, 1, 0, 0, 3'b001, 2'd0));
        add_vec(4'h5, 0, 0, 1, 1, mm(1, 0, 0, 0), ex(1, 0, 1, 0, 0, 3'b010, 2'd0));
        add_vec(4'h6, 0, 0, 0, 1, mm(1, 0, 0, 0), ex(1, 0, 1, 0, 0, 3'b011, 2'd0));
        add_vec(4'h7, 0, 7, 7, 1, mm(1, 0, 0, 0), ex(1, 0, 1, 0, 0, 3'b100, 2'd0));
        add_vec(4'h8, 0, 0, 0, 0, '0, ex(0, 0, 1, 0, 0, 3'b110, 2'd0));
        add_vec(4'h9, 0, 0, 0, 0, '0, ex(0, 0, 0, 0, 0, 3'b000, 2'd1));
        add_vec(4'hB, 0, 0, 3, 1, mm(1, 0, 0, 0), ex(1, 0, 0, 0, 0, 3'b000, 2'd2));
        add_vec(4'hC, 0, 1, 1, 1, mm(1, 0, 1, 0), ex(1, 1, 1, 1, 0, 3'b000, 2'd0));
        add_vec(4'h2, 0, 0, 0, 1, mm(0, 1, 0, 0), ex(0, 0, 0, 0, 0, 3'b000, 2'd0));
        add_vec(4'hE, 0, 0, 0, 0, '0, ex(0, 0, 0, 0, 1, 3'b000, 2'd0));
        add_vec(4'hF, 1, 3, 0, 0, '0, ex(0, 0, 0, 0, 0, 3'b000, 2'd0));

        // Reset held with live inputs: every output must read 0
        start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; opcode = 4'h5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", '0);
        rst = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        step("idle", '0);
        start = 1'b1;
        step("idle_start", '0);
        start = 1'b0;

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].az, vecs[i].di, vecs[i].dd, vecs[i].has_mem,
                      vecs[i].mem, vecs[i].exe);
        end

        run_instr(4'h0, 1'b0, 1, 0, 1'b0, '0, '0);
        resume_from_halt();

        repeat (40) begin
            logic [3:0] op;
            logic       az;
            op = 4'($urandom_range(0, 15));
            az = 1'($urandom);
            run_instr(op, az, $urandom_range(0, 7), $urandom_range(0, 7), m_reads(op) | m_writes(op),
                      m_mem(op), m_exec(op, az));
            if (op == 4'h0) resume_from_halt();
        end

        // Reset in the middle of a store: the write request must drop without a clock edge
        a_zero = 1'b0; start = 1'b0; dmem_ack = 1'b0;
        opcode = 4'h2; imem_ack = 1'b1;
        step("rstmem_fetch", o_fetch());
        imem_ack = 1'b0;
        step("rstmem_decode", '0);
        step("rstmem_mem", mm(0, 1, 0, 0));
        #2;
        rst = 1'b1;
        ret_model = 0;
        #1;
        check("rst_async_mem", '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Watchdog: imem never acks, ERROR after 8 wait cycles and start is ignored
        start = 1'b1;
        step("to_idle", '0);
        start = 1'b0;
        for (int c = 0; c < 8; c++) step("to_wait", o_fetch());
        for (int c = 0; c < 3; c++) begin
            start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
            step("to_err", o_err());
        end
        start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("to_rst_clears", '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("post_rst_idle", '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
